// File: rtl/net_ack_pkg.sv
// ============================================================================
// Module   : net_ack_pkg
// Purpose  : Shared constants and types for the BPI status/ack reply receiver.
//            Frame layout: 8 echoed command bytes, 4 pad bytes, 1 ack code.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package net_ack_pkg;

  localparam int FRAME_LEN = 13;
  localparam int HDR_LEN   = 8;
  localparam int PAD_LEN   = 4;
  localparam int CODE_IDX  = 12;
  localparam int IDX_W     = 4;
  localparam int HDR_W     = 8 * HDR_LEN;

  localparam logic [7:0] DEF_PAD_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RECV  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/net_ack_timer.sv
// ============================================================================
// Module   : net_ack_timer
// Purpose  : Reply timeout counter. Counts while enabled, holds at the
//            terminal count, and returns to zero on clear.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            clr         - synchronous clear to 0 (has priority over en)
//            en          - count enable
//            tc          - count == TIMEOUT_CYC-1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_ack_timer
  import net_ack_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TMR_W       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  assign tc = (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/net_ack_rx.sv
// ============================================================================
// Module   : net_ack_rx
// Purpose  : Receiver for the 13-byte BPI status/ack reply frame. Arms on each
//            issued command, times out if no reply starts, then checks length
//            and pad bytes, decodes the ack code and compares the echoed header
//            against the command snapshot.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            cmd_sent/cmd_word - command issue pulse and its 8 bytes
//            ack_din_en/ack_din- reply byte stream (one contiguous run/frame)
//            ack_valid         - pulse, good frame decoded
//            ack_code/ack_hdr  - code and header of last good frame
//            hdr_match/unsol   - header compare / arrived while not armed
//            err_len/err_pad/err_timeout - error pulses
//            busy              - state != IDLE
//            stat_good/stat_err- saturating counters (NET_ACK_STAT_CNT_EN)
// Options  : NET_ACK_STAT_CNT_EN adds the statistics counters and ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_ack_rx
  import net_ack_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         TMR_W       = 20,
  parameter logic [7:0] PAD_BYTE    = DEF_PAD_BYTE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_sent,
  input  logic [63:0]      cmd_word,
  input  logic             ack_din_en,
  input  logic [7:0]       ack_din,
  output logic             ack_valid,
  output logic [7:0]       ack_code,
  output logic [HDR_W-1:0] ack_hdr,
  output logic             hdr_match,
  output logic             unsol,
  output logic             err_len,
  output logic             err_pad,
  output logic             err_timeout,
  output logic             busy
`ifdef NET_ACK_STAT_CNT_EN
  ,
  output logic [15:0]      stat_good,
  output logic [15:0]      stat_err
`endif
);

  state_e state_q, state_d;

  logic [63:0]      exp_q, exp_d;
  logic [HDR_W-1:0] snap_q, snap_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [7:0]       code_cap_q, code_cap_d;
  logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             pad_fail_q, pad_fail_d;
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
  logic             unsol_pend_q, unsol_pend_d;
  logic             en_prev_q, en_prev_d;
  logic             sync_q, sync_d;

  logic             ack_valid_q, ack_valid_d;
  logic [7:0]       ack_code_q, ack_code_d;
  logic [HDR_W-1:0] ack_hdr_q, ack_hdr_d;
  logic             hdr_match_q, hdr_match_d;
  logic             unsol_q, unsol_d;
  logic             err_len_q, err_len_d;
  logic             err_pad_q, err_pad_d;
  logic             err_timeout_q, err_timeout_d;

  logic             frame_start;
  logic             frame_end;
  logic             timeout_fire;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic             len_ok;
  logic             take;
  logic [IDX_W-1:0] idx;

  // sync_q stays low until the stream has been seen idle once after reset, so
  // a run already in progress at reset release is never taken as a frame.
  assign frame_start = sync_q && ack_din_en && !en_prev_q && (state_q != RECV);
  assign frame_end   = (state_q == RECV) && !ack_din_en;

  net_ack_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_start)   state_d = RECV;
        else if (cmd_sent) state_d = ARMED;
      end
      ARMED: begin
        // A frame arriving on the terminal-count cycle wins over the timeout;
        // a re-issued command restarts the wait instead of timing out.
        if (frame_start)              state_d = RECV;
        else if (tmr_tc && !cmd_sent) state_d = IDLE;
      end
      RECV: begin
        if (!ack_din_en) state_d = (pend_q || cmd_sent) ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- state-derived controls ----------------
  always_comb begin
    tmr_clr      = (state_q != ARMED) || cmd_sent;
    tmr_en       = (state_q == ARMED);
    timeout_fire = (state_q == ARMED) && tmr_tc && !frame_start && !cmd_sent;
  end

  // ---------------- frame capture and result datapath ----------------
  always_comb begin
    exp_d         = cmd_sent ? cmd_word : exp_q;
    snap_d        = snap_q;
    hdr_d         = hdr_q;
    code_cap_d    = code_cap_q;
    byte_cnt_d    = byte_cnt_q;
    pad_fail_d    = pad_fail_q;
    ovf_d         = ovf_q;
    pend_d        = pend_q;
    unsol_pend_d  = unsol_pend_q;
    en_prev_d     = ack_din_en;
    sync_d        = sync_q | ~ack_din_en;

    ack_valid_d   = 1'b0;
    ack_code_d    = ack_code_q;
    ack_hdr_d     = ack_hdr_q;
    hdr_match_d   = hdr_match_q;
    unsol_d       = unsol_q;
    err_len_d     = 1'b0;
    err_pad_d     = 1'b0;
    err_timeout_d = timeout_fire;

    take = frame_start || ((state_q == RECV) && ack_din_en);
    idx  = frame_start ? '0 : byte_cnt_q;
    len_ok = (byte_cnt_q == IDX_W'(FRAME_LEN)) && !ovf_q;

    if (frame_start) begin
      snap_d       = exp_q;
      pad_fail_d   = 1'b0;
      ovf_d        = 1'b0;
      unsol_pend_d = (state_q != ARMED);
      pend_d       = cmd_sent;
    end else if (state_q == RECV) begin
      pend_d = frame_end ? 1'b0 : (pend_q | cmd_sent);
    end

    if (take) begin
      if (idx < IDX_W'(FRAME_LEN)) begin
        byte_cnt_d = idx + IDX_W'(1);
        if (idx < IDX_W'(HDR_LEN)) begin
          hdr_d = {hdr_q[HDR_W-9:0], ack_din};
        end else if (idx < IDX_W'(HDR_LEN + PAD_LEN)) begin
          if (ack_din != PAD_BYTE) pad_fail_d = 1'b1;
        end else begin
          code_cap_d = ack_din;
        end
      end else begin
        // Count saturates at 13; the overrun flag keeps long frames visible.
        ovf_d = 1'b1;
      end
    end

    if (frame_end) begin
      byte_cnt_d = '0;
      err_len_d  = !len_ok;
      err_pad_d  = pad_fail_q;
      if (len_ok && !pad_fail_q) begin
        ack_valid_d = 1'b1;
        ack_code_d  = code_cap_q;
        ack_hdr_d   = hdr_q;
        hdr_match_d = (hdr_q == snap_q);
        unsol_d     = unsol_pend_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q         <= '0;
      snap_q        <= '0;
      hdr_q         <= '0;
      code_cap_q    <= '0;
      byte_cnt_q    <= '0;
      pad_fail_q    <= 1'b0;
      ovf_q         <= 1'b0;
      pend_q        <= 1'b0;
      unsol_pend_q  <= 1'b0;
      en_prev_q     <= 1'b0;
      sync_q        <= 1'b0;
      ack_valid_q   <= 1'b0;
      ack_code_q    <= '0;
      ack_hdr_q     <= '0;
      hdr_match_q   <= 1'b0;
      unsol_q       <= 1'b0;
      err_len_q     <= 1'b0;
      err_pad_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      exp_q         <= exp_d;
      snap_q        <= snap_d;
      hdr_q         <= hdr_d;
      code_cap_q    <= code_cap_d;
      byte_cnt_q    <= byte_cnt_d;
      pad_fail_q    <= pad_fail_d;
      ovf_q         <= ovf_d;
      pend_q        <= pend_d;
      unsol_pend_q  <= unsol_pend_d;
      en_prev_q     <= en_prev_d;
      sync_q        <= sync_d;
      ack_valid_q   <= ack_valid_d;
      ack_code_q    <= ack_code_d;
      ack_hdr_q     <= ack_hdr_d;
      hdr_match_q   <= hdr_match_d;
      unsol_q       <= unsol_d;
      err_len_q     <= err_len_d;
      err_pad_q     <= err_pad_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // ---------------- outputs ----------------
  assign ack_valid   = ack_valid_q;
  assign ack_code    = ack_code_q;
  assign ack_hdr     = ack_hdr_q;
  assign hdr_match   = hdr_match_q;
  assign unsol       = unsol_q;
  assign err_len     = err_len_q;
  assign err_pad     = err_pad_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != IDLE);

`ifdef NET_ACK_STAT_CNT_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_good_d = stat_good_q;
    stat_err_d  = stat_err_q;
    if (ack_valid_q && (stat_good_q != 16'hFFFF)) begin
      stat_good_d = stat_good_q + 16'd1;
    end
    if ((err_len_q || err_pad_q || err_timeout_q) && (stat_err_q != 16'hFFFF)) begin
      stat_err_d = stat_err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_net_ack_rx.sv
// ============================================================================
// Module   : tb_net_ack_rx
// Purpose  : Scoreboard bench for net_ack_rx. Stimulus pushes expected result
//            events; a negedge monitor pops and compares every DUT result.
// Options  : NET_ACK_STAT_CNT_EN also checks the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_ack_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_sent;
  logic [63:0] cmd_word;
  logic        ack_din_en;
  logic [7:0]  ack_din;
  logic        ack_valid;
  logic [7:0]  ack_code;
  logic [63:0] ack_hdr;
  logic        hdr_match;
  logic        unsol;
  logic        err_len;
  logic        err_pad;
  logic        err_timeout;
  logic        busy;
`ifdef NET_ACK_STAT_CNT_EN
  logic [15:0] stat_good;
  logic [15:0] stat_err;
`endif

  net_ack_rx #(
    .TIMEOUT_CYC (16),
    .TMR_W       (20),
    .PAD_BYTE    (8'hFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_sent    (cmd_sent),
    .cmd_word    (cmd_word),
    .ack_din_en  (ack_din_en),
    .ack_din     (ack_din),
    .ack_valid   (ack_valid),
    .ack_code    (ack_code),
    .ack_hdr     (ack_hdr),
    .hdr_match   (hdr_match),
    .unsol       (unsol),
    .err_len     (err_len),
    .err_pad     (err_pad),
    .err_timeout (err_timeout),
    .busy        (busy)
`ifdef NET_ACK_STAT_CNT_EN
    ,
    .stat_good   (stat_good),
    .stat_err    (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    bit          el;
    bit          ep;
    bit          et;
    logic [7:0]  code;
    logic [63:0] hdr;
    bit          m;
    bit          u;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  fq[$];

  // Model of the held "last good frame" outputs.
  logic [7:0]  m_code  = '0;
  logic [63:0] m_hdr   = '0;
  bit          m_match = 1'b0;
  bit          m_unsol = 1'b0;
  int          n_good  = 0;
  int          n_err   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_good(input logic [63:0] h, input logic [7:0] c,
                           input bit m, input bit u, input int at);
    exp_t e;
    m_code = c; m_hdr = h; m_match = m; m_unsol = u;
    e.v = 1'b1; e.el = 1'b0; e.ep = 1'b0; e.et = 1'b0;
    e.code = c; e.hdr = h; e.m = m; e.u = u; e.at = at;
    sb.push_back(e);
    n_good++;
  endtask

  task automatic push_err(input bit el, input bit ep, input bit et, input int at);
    exp_t e;
    e.v = 1'b0; e.el = el; e.ep = ep; e.et = et;
    e.code = m_code; e.hdr = m_hdr; e.m = m_match; e.u = m_unsol; e.at = at;
    sb.push_back(e);
    n_err++;
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (ack_valid || err_len || err_pad || err_timeout)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: actual v/el/ep/et=%b%b%b%b required none (cyc %0d)",
                 ack_valid, err_len, err_pad, err_timeout, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("evt_flags", {60'd0, ack_valid, err_len, err_pad, err_timeout},
              {60'd0, mon_e.v, mon_e.el, mon_e.ep, mon_e.et});
        check("evt_cycle", 64'(cyc), 64'(mon_e.at));
        check("ack_code", {56'd0, ack_code}, {56'd0, mon_e.code});
        check("ack_hdr", ack_hdr, mon_e.hdr);
        check("hdr_match", {63'd0, hdr_match}, {63'd0, mon_e.m});
        check("unsol", {63'd0, unsol}, {63'd0, mon_e.u});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic std_frame(input logic [63:0] h, input logic [7:0] c);
    logic [63:0] hv;
    hv = h;
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(hv[63-8*i -: 8]);
    for (int i = 0; i < 4; i++) fq.push_back(8'hFF);
    fq.push_back(c);
  endtask

  // Called just after a posedge; first byte is sampled on the next edge.
  task automatic drive_frame(input int cmd_at, input logic [63:0] w);
    for (int i = 0; i < fq.size(); i++) begin
      ack_din_en = 1'b1;
      ack_din    = fq[i];
      if (i == cmd_at) begin
        cmd_sent = 1'b1;
        cmd_word = w;
      end else begin
        cmd_sent = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    cmd_sent   = 1'b0;
    ack_din_en = 1'b0;
    ack_din    = '0;
  endtask

  task automatic send_cmd(input logic [63:0] w, output int k);
    cmd_sent = 1'b1;
    cmd_word = w;
    k        = cyc;
    @(posedge clk);
    #1;
    cmd_sent = 1'b0;
  endtask

  task automatic check_stats(input string nm);
`ifdef NET_ACK_STAT_CNT_EN
    check({nm, "_stat_good"}, {48'd0, stat_good}, 64'(n_good));
    check({nm, "_stat_err"}, {48'd0, stat_err}, 64'(n_err));
`else
    if (nm.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int s;
    rst_n      = 1'b0;
    cmd_sent   = 1'b0;
    cmd_word   = '0;
    ack_din_en = 1'b0;
    ack_din    = '0;
    idle(3);
    check("rst_hdr", ack_hdr, 64'd0);
    check("rst_misc", {49'd0, ack_valid, ack_code, hdr_match, unsol, err_len, err_pad,
                       err_timeout, busy}, 64'd0);
    rst_n = 1'b1;
    idle(3);

    // T1: armed, matching reply
    send_cmd(64'h0102030405060708, k);
    idle(2);
    check("busy_armed", {63'd0, busy}, 64'd1);
    std_frame(64'h0102030405060708, 8'h5A);
    s = cyc;
    push_good(64'h0102030405060708, 8'h5A, 1'b1, 1'b0, s + 13 + 1);
    drive_frame(-1, '0);
    idle(3);
    check("busy_after_t1", {63'd0, busy}, 64'd0);

    // T2: header mismatch in last byte
    send_cmd(64'h0102030405060708, k);
    idle(2);
    std_frame(64'h0102030405060709, 8'h33);
    s = cyc;
    push_good(64'h0102030405060709, 8'h33, 1'b0, 1'b0, s + 14);
    drive_frame(-1, '0);
    idle(3);

    // T3: pad byte 10 wrong -> err_pad, outputs held
    send_cmd(64'h0102030405060708, k);
    idle(2);
    std_frame(64'h0102030405060708, 8'h77);
    fq[10] = 8'hFE;
    s = cyc;
    push_err(1'b0, 1'b1, 1'b0, s + 14);
    drive_frame(-1, '0);
    idle(3);

    // T4: 12-byte frame
    std_frame(64'h1111111111111111, 8'h99);
    void'(fq.pop_back());
    s = cyc;
    push_err(1'b1, 1'b0, 1'b0, s + 12 + 1);
    drive_frame(-1, '0);
    idle(3);

    // T5: 15-byte frame, otherwise well formed
    std_frame(64'h0102030405060708, 8'h66);
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    s = cyc;
    push_err(1'b1, 1'b0, 1'b0, s + 15 + 1);
    drive_frame(-1, '0);
    idle(3);

    // T6: timeout 16 cycles after arming
    send_cmd(64'hCAFE0000CAFE0000, k);
    push_err(1'b0, 1'b0, 1'b1, k + 17);
    idle(20);
    check("busy_after_timeout", {63'd0, busy}, 64'd0);

    // T7: frame starts on the terminal-count cycle -> frame wins
    send_cmd(64'hA1A2A3A4A5A6A7A8, k);
    idle(15);
    std_frame(64'hA1A2A3A4A5A6A7A8, 8'h11);
    s = cyc;
    push_good(64'hA1A2A3A4A5A6A7A8, 8'h11, 1'b1, 1'b0, s + 14);
    drive_frame(-1, '0);
    idle(20);

    // T8: command issued mid-frame -> old snapshot used, then re-armed
    send_cmd(64'hB1B2B3B4B5B6B7B8, k);
    idle(2);
    std_frame(64'hB1B2B3B4B5B6B7B8, 8'h22);
    s = cyc;
    push_good(64'hB1B2B3B4B5B6B7B8, 8'h22, 1'b1, 1'b0, s + 14);
    drive_frame(5, 64'hC1C2C3C4C5C6C7C8);
    idle(2);
    check("busy_pending_arm", {63'd0, busy}, 64'd1);
    std_frame(64'hC1C2C3C4C5C6C7C8, 8'h44);
    s = cyc;
    push_good(64'hC1C2C3C4C5C6C7C8, 8'h44, 1'b1, 1'b0, s + 14);
    drive_frame(-1, '0);
    idle(3);
    check("busy_after_t8", {63'd0, busy}, 64'd0);
    check_stats("pre_reset");

    // T9: reset mid-frame, released while the stream is still high
    ack_din_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ack_din = 8'h50 + 8'(i);
      idle(1);
    end
    rst_n = 1'b0;
    idle(2);
    check("midrst_hdr", ack_hdr, 64'd0);
    check("midrst_misc", {49'd0, ack_valid, ack_code, hdr_match, unsol, err_len, err_pad,
                          err_timeout, busy}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack_din = 8'hEE;
      idle(1);
    end
    check("busy_ignored_run", {63'd0, busy}, 64'd0);
    ack_din_en = 1'b0;
    ack_din    = '0;
    m_code = '0; m_hdr = '0; m_match = 1'b0; m_unsol = 1'b0;
    n_good = 0;  n_err = 0;
    idle(3);
    // Expected register was reset to 0, so an all-zero header matches.
    std_frame(64'h0000000000000000, 8'hC3);
    s = cyc;
    push_good(64'h0000000000000000, 8'hC3, 1'b1, 1'b1, s + 14);
    drive_frame(-1, '0);
    idle(5);
    check_stats("final");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/net_ack_rx.md
Name: net_ack_rx

Overview:
- Receiver for the 13-byte BPI status/ack reply frame on the control byte stream.
- Frame layout: 8 echoed command bytes, 4 pad bytes of 8'hFF, 1 ack code byte.
- Sits on the host/control side. Arms on each issued BPI command, watches for the reply within a timeout, then validates, decodes and reports it.

Parameters:
- TIMEOUT_CYC, 1000000: cycles in ARMED with no frame start before err_timeout fires.
- TMR_W, 20: timeout counter width. Must hold TIMEOUT_CYC-1.
- PAD_BYTE, 8'hFF: required value of bytes 8..11.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cmd_sent  in  1  one-cycle pulse: a BPI command was issued
- cmd_word  in  64  issued command bytes; byte0 = [63:56]; valid with cmd_sent
- ack_din_en  in  1  byte strobe; a frame is one contiguous high run
- ack_din  in  8  frame byte
- ack_valid  out  1  one-cycle pulse: good frame decoded
- ack_code  out  8  byte 12 of last good frame
- ack_hdr  out  64  bytes 0..7 of last good frame
- hdr_match  out  1  ack_hdr equals expected command snapshot
- unsol  out  1  last good frame arrived while not ARMED
- err_len  out  1  pulse: frame length != 13
- err_pad  out  1  pulse: a pad byte != PAD_BYTE
- err_timeout  out  1  pulse: no reply within TIMEOUT_CYC
- busy  out  1  state != IDLE

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0. Internal expected register 0. State IDLE. Byte count 0.
- States: IDLE, ARMED, RECV.
  - IDLE -> ARMED on cmd_sent. Latch cmd_word, clear timer.
  - IDLE -> RECV on frame start; unsolicited.
  - ARMED -> RECV on frame start. Timer stops.
  - ARMED -> IDLE when timer == TIMEOUT_CYC-1. err_timeout pulses that cycle.
  - RECV -> ARMED or IDLE at frame end. Go to ARMED if a pending-arm bit is set, else IDLE.
- Frame start: ack_din_en high while it was low the previous cycle.
- Frame end: first cycle ack_din_en is sampled low after a run.
- Byte index: 4-bit count, 0 at frame start. Saturates at 13; bytes beyond index 12 are dropped.
- Capture rules:
  - Bytes 0..7 shift into a header register.
  - Bytes 8..11 are compared to PAD_BYTE; any mismatch sets a sticky pad-fail bit.
  - Byte 12 is captured as the code.
- Expected snapshot: copied from the expected register at frame start. hdr_match compares against this snapshot.
- Result timing: results are registered and appear 1 cycle after frame end.
  - Length 13 and pads good: ack_valid=1; ack_code, ack_hdr, hdr_match and unsol update.
  - Length != 13: err_len=1, outputs held, no ack_valid.
  - Pad fail with length 13: err_pad=1, outputs held, no ack_valid.
  - Both faults: both error pulses assert.
- cmd_sent in ARMED: re-latch cmd_word and restart the timer.
- cmd_sent in RECV: re-latch cmd_word and set the pending-arm bit. The current frame still uses its snapshot.
- Simultaneous frame start and timeout terminal count: the frame wins; no err_timeout.
- Simultaneous frame end and cmd_sent: result is reported and the block enters ARMED.
- Reset mid-frame: partial frame discarded.
- Stream resync after reset: if ack_din_en is already high when rst_n releases, that run is ignored via a sync bit. Parsing starts at the next frame start.
- Back-to-back frames need at least 1 idle cycle; there is no gap-free framing.

Optional Feature:
- Macro: NET_ACK_STAT_CNT_EN.
- Defined: adds outputs stat_good[15:0] and stat_err[15:0]. Both are saturating counters, reset to 0.
  - stat_good increments on ack_valid.
  - stat_err increments once per cycle on which any err_* pulses.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package net_ack_pkg holds: FRAME_LEN=13, HDR_LEN=8, PAD_LEN=4, CODE_IDX=12, default PAD_BYTE, and the state enum {IDLE, ARMED, RECV}.
- One sub-module, net_ack_timer: a TMR_W-bit counter with clear/enable inputs and a terminal-count output.

Test Plan:
- cmd_sent with cmd_word=64'h0102030405060708, then frame 01..08,FF,FF,FF,FF,5A -> ack_valid pulse 1 cycle after frame end; ack_code=8'h5A; hdr_match=1; unsol=0; busy=0 after.
- Same command, reply header 01..07,09 -> ack_valid=1 and hdr_match=0.
- Frame with byte 10 = 8'hFE -> err_pad=1, no ack_valid, ack_code keeps its previous value.
- 12-byte frame -> err_len=1. 15-byte frame -> err_len=1; bytes 13,14 dropped.
- TIMEOUT_CYC=16, cmd_sent and no frame -> err_timeout exactly 16 cycles after arming. Frame start on cycle 15 -> no timeout, normal decode.
- Assert rst_n low mid-frame, release with ack_din_en high -> that run ignored; next clean frame decodes with unsol=1. With NET_ACK_STAT_CNT_EN, check the counters.
